// File: rtl/spike_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : spike_fifo_writer
// Purpose  : Producer side of the spike event FIFO. Holds an N-bit input
//            spike bitmap written by the host over OBI, snapshots it on every
//            tick trigger and pushes the index of every set bit into the FIFO
//            in ascending order, then raises spikecore_done_o.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RSTN            clock, asynchronous active-low reset
//   spike_slave_req_i    OBI request  {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   spike_slave_resp_o   OBI response {gnt, rvalid, rdata[31:0]}
//   start_i              controller start level
//   next_tick_i          tick pulse from tick generator
//   FIFO_w_en_o          FIFO push strobe
//   FIFO_w_data_o        neuron index pushed
//   FIFO_full_i          FIFO full
//   spikecore_done_o     scan complete (level, held until next trigger)
//   busy_o               scan in progress
// Memory map (word index = addr[$clog2(N/32)+2:2])
//   0 .. N/32-1  shadow bitmap words (bit b of word w is neuron 32w+b)
//   N/32         STATUS {count @ [16+], overrun[2] (clear on read), done[1], busy[0]}
// Configuration macro
//   SPIKE_FIFO_WRITER_AUTOCLEAR_EN : clear shadow on every snapshot
// ============================================================================
module spike_fifo_writer #(
  parameter int unsigned N     = 256,
  parameter type         req_t = logic [69:0],
  parameter type         rsp_t = logic [33:0]
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  req_t                 spike_slave_req_i,
  output rsp_t                 spike_slave_resp_o,
  input  logic                 start_i,
  input  logic                 next_tick_i,
  output logic                 FIFO_w_en_o,
  output logic [$clog2(N)-1:0] FIFO_w_data_o,
  input  logic                 FIFO_full_i,
  output logic                 spikecore_done_o,
  output logic                 busy_o
);

  localparam int unsigned NW  = N / 32;
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned CW  = IW + 1;
  localparam int unsigned AW  = $clog2(NW) + 1;
  localparam int unsigned WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WIW-1:0] LAST_WORD = WIW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Request field split
  logic [69:0]   w_req;
  logic          w_req_v;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_bmask;
  logic [AW-1:0] w_widx;
  logic          w_unused_ok;

  assign w_req       = spike_slave_req_i;
  assign w_req_v     = w_req[69];
  assign w_we        = w_req[68];
  assign w_be        = w_req[67:64];
  assign w_addr      = w_req[63:32];
  assign w_wdata     = w_req[31:0];
  assign w_bmask     = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_widx      = w_addr[AW+1:2];
  assign w_unused_ok = ^{w_addr[31:AW+2], w_addr[1:0]};

  state_t          state_q, state_d;
  logic            start_q;
  logic [N-1:0]    shadow_q, shadow_d;
  logic [N-1:0]    work_q, work_d;
  logic [WIW-1:0]  word_idx_q, word_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            rvalid_q;
  logic [31:0]     rdata_q, rdata_d;

  logic            w_trig;
  logic [31:0]     w_cur_word;
  logic [4:0]      w_lsb;
  logic            w_push;

  assign w_trig = (start_i & ~start_q) | (next_tick_i & start_i);

  // Current work word and its lowest set bit (descending loop: lowest wins)
  always_comb begin
    w_cur_word = '0;
    for (int w = 0; w < NW; w++) begin
      if (word_idx_q == WIW'(w)) w_cur_word = work_q[w*32 +: 32];
    end
    w_lsb = '0;
    for (int b = 31; b >= 0; b--) begin
      if (w_cur_word[b]) w_lsb = 5'(b);
    end
  end

  assign w_push           = (state_q == S_SCAN) && (w_cur_word != '0) && !FIFO_full_i;
  assign FIFO_w_en_o      = w_push;
  assign FIFO_w_data_o    = w_push ? IW'({word_idx_q, w_lsb}) : '0;
  assign busy_o           = (state_q == S_SCAN);
  assign spikecore_done_o = (state_q == S_DONE);

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    work_d     = work_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    rdata_d    = '0;

    // Host reads; a STATUS read clears overrun (a same-cycle set wins below)
    if (w_req_v && !w_we) begin
      for (int w = 0; w < NW; w++) begin
        if (w_widx == AW'(w)) rdata_d = shadow_q[w*32 +: 32];
      end
      if (w_widx == AW'(NW)) begin
        rdata_d[0]       = busy_o;
        rdata_d[1]       = spikecore_done_o;
        rdata_d[2]       = overrun_q;
        rdata_d[16 +: CW] = count_q;
        overrun_d        = 1'b0;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_trig) begin
          work_d     = shadow_q;
          word_idx_d = '0;
          count_d    = '0;
          state_d    = S_SCAN;
`ifdef SPIKE_FIFO_WRITER_AUTOCLEAR_EN
          shadow_d   = '0;
`else
          shadow_d   = shadow_q;
`endif
        end
      end
      S_SCAN: begin
        if (w_trig) overrun_d = 1'b1;
        if (w_cur_word != '0) begin
          if (!FIFO_full_i) begin
            for (int w = 0; w < NW; w++) begin
              if (word_idx_q == WIW'(w))
                work_d[w*32 +: 32] = w_cur_word & (w_cur_word - 32'd1);
            end
            count_d = count_q + CW'(1);
          end
        end else if (word_idx_q == LAST_WORD) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + WIW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Host write lands after the snapshot/clear, so it overrides both
    if (w_req_v && w_we) begin
      for (int w = 0; w < NW; w++) begin
        if (w_widx == AW'(w))
          shadow_d[w*32 +: 32] = (shadow_d[w*32 +: 32] & ~w_bmask) | (w_wdata & w_bmask);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      shadow_q   <= '0;
      work_q     <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_i;
      shadow_q   <= shadow_d;
      work_q     <= work_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      rvalid_q   <= w_req_v;
      rdata_q    <= rdata_d;
    end
  end

  assign spike_slave_resp_o = {w_req_v, rvalid_q, rdata_q};

endmodule
`default_nettype wire
